// File: rtl/ascii_decimal_decoder_if.sv
// Byte-in / number-out stream bundle for the ASCII decimal decoder.
// The decoder takes the slave side; whoever feeds bytes and drains numbers takes master.
interface ascii_decimal_decoder_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
);
    localparam int unsigned CntW = $clog2(1 + DIGITS);

    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [CntW-1:0]  out_digits;
    logic             out_overflow;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_digits, out_overflow
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_value, out_digits, out_overflow
    );
endinterface

// File: rtl/ascii_decimal_decoder.sv
// Turns each maximal run of ASCII '0'..'9' into one binary word with digit count and
// overflow flag; any other byte terminates the run and is dropped.
module ascii_decimal_decoder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input logic                   clk,
    input logic                   reset,
    ascii_decimal_decoder_if.slave bus
);
    localparam int unsigned CntW = $clog2(1 + DIGITS);

    typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_value_q;
    logic [CntW-1:0]  out_digits_q;
    logic             out_overflow_q;

    logic             is_digit;
    logic             take;
    logic [3:0]       digit;
    logic [WIDTH+3:0] acc_x10;
    logic             cnt_full;

    assign is_digit    = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    assign digit       = bus.in_data[3:0];
    assign bus.in_ready = (state_q != StEmit);
    assign take        = bus.in_valid && bus.in_ready;
    assign cnt_full    = (cnt_q == CntW'(DIGITS));

    // Four guard bits catch any carry out of WIDTH from acc*10 + d.
    assign acc_x10 = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1)
                   + {{WIDTH{1'b0}}, digit};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (take && is_digit) begin
                    acc_d   = WIDTH'(digit);
                    cnt_d   = CntW'(1);
                    ovf_d   = 1'b0;
                    state_d = bus.in_last ? StEmit : StAccum;
                end
            end
            StAccum: begin
                if (take) begin
                    if (is_digit) begin
                        acc_d = acc_x10[WIDTH-1:0];
                        ovf_d = ovf_q | (|acc_x10[WIDTH+3:WIDTH]) | cnt_full;
                        if (!cnt_full) cnt_d = cnt_q + CntW'(1);
                        if (bus.in_last) state_d = StEmit;
                    end else begin
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Output fields are captured once on entry to StEmit so they stay stable until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_value_q    <= '0;
            out_digits_q   <= '0;
            out_overflow_q <= 1'b0;
        end else if (state_q != StEmit && state_d == StEmit) begin
            out_valid_q    <= 1'b1;
            out_value_q    <= acc_d;
            out_digits_q   <= cnt_d;
            out_overflow_q <= ovf_d;
        end else if (state_q == StEmit && bus.out_ready) begin
            out_valid_q    <= 1'b0;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_value    = out_value_q;
    assign bus.out_digits   = out_digits_q;
    assign bus.out_overflow = out_overflow_q;
endmodule
